// File: rtl/pc_gen_ras_pkg.sv
// Shared constants for the next-PC generator: default PC width, reset PC
// and the two instruction lengths used by the sequential adder.
package pc_gen_ras_pkg;

    localparam int unsigned PC_W_DEF     = 16;
    localparam int unsigned RESET_PC_DEF = 0;
    localparam int unsigned ILEN_C       = 2;  // compressed instruction
    localparam int unsigned ILEN_N       = 4;  // full-width instruction

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_gen_ras_if.sv
// Fetch-control bus between predictor/decoder (master) and the next-PC
// generator (slave).
//  master drives: pc_move, flush_flag, wait_exe, wait_jmp, decompr_en,
//                 jmp_pred, is_call, is_ret, pc_now, pc_jmp
//  slave drives : pc (comb), ras_hit (comb), ras_cnt (registered)
interface pc_gen_ras_if
    import pc_gen_ras_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = cnt_w(RAS_DEPTH);

    logic             pc_move;
    logic             flush_flag;
    logic             wait_exe;
    logic             wait_jmp;
    logic             decompr_en;
    logic             jmp_pred;
    logic             is_call;
    logic             is_ret;
    logic [PC_W-1:0]  pc_now;
    logic [PC_W-1:0]  pc_jmp;
    logic [PC_W-1:0]  pc;
    logic             ras_hit;
    logic [CNT_W-1:0] ras_cnt;

    modport master (
        output pc_move, flush_flag, wait_exe, wait_jmp, decompr_en,
               jmp_pred, is_call, is_ret, pc_now, pc_jmp,
        input  pc, ras_hit, ras_cnt
    );

    modport slave (
        input  pc_move, flush_flag, wait_exe, wait_jmp, decompr_en,
               jmp_pred, is_call, is_ret, pc_now, pc_jmp,
        output pc, ras_hit, ras_cnt
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack.
//  push/pop : may both be set; then the top entry is replaced in place
//  clr      : invalidates all entries (count -> 0)
//  top      : most recent entry (meaningful only when cnt != 0)
//  cnt      : number of valid entries, saturates at DEPTH
// A push when full overwrites the oldest entry, which is the slot just
// above the top pointer in the ring.
module pc_ras
    import pc_gen_ras_pkg::*;
#(
    parameter int unsigned W     = PC_W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clr,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              top,
    output logic [cnt_w(DEPTH)-1:0]   cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] wr_idx;

    assign ptr_inc = ptr + PTR_W'(1);
    assign wr_idx  = pop ? ptr : ptr_inc;
    assign top     = mem[ptr];

    // Pointer and count; a combined push+pop leaves both unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (push && !pop) begin
            ptr <= ptr_inc;
            if (cnt != CNT_W'(DEPTH)) cnt <= cnt + CNT_W'(1);
        end else if (pop && !push && cnt != '0) begin
            ptr <= ptr - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Next-PC generator for the fetch stage with return-address stack.
// Picks reset / flush-recovery / stall / RAS / predicted / sequential PC and
// records, per advancing cycle, the PC of the path not taken so that a
// misprediction flagged FLUSH_LAT cycles later can restore it.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : pc_gen_ras_if.slave (see interface for signal list)
module pc_gen_ras
    import pc_gen_ras_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned RESET_PC  = RESET_PC_DEF,
    parameter int unsigned FLUSH_LAT = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_gen_ras_if.slave   bus
);
    logic                             stall;
    logic                             adv;
    logic                             ras_ok;
    logic                             ras_hit_c;
    logic [PC_W-1:0]                  seq;
    logic [PC_W-1:0]                  alt;
    logic [PC_W-1:0]                  ras_top;
    logic [FLUSH_LAT-1:0][PC_W-1:0]   fq;
    logic [FLUSH_LAT-1:0][PC_W-1:0]   fq_d;

    assign stall     = bus.wait_exe | bus.wait_jmp;
    assign adv       = bus.pc_move & ~bus.flush_flag & ~stall;
    assign seq       = bus.pc_now + (bus.decompr_en ? PC_W'(ILEN_C) : PC_W'(ILEN_N));
    assign ras_ok    = bus.is_ret & (bus.ras_cnt != '0);
    assign ras_hit_c = adv & ras_ok;
    assign bus.ras_hit = ras_hit_c;

    // Next-PC priority mux.
    always_comb begin
        bus.pc = seq;
        if (!bus.pc_move)         bus.pc = PC_W'(RESET_PC);
        else if (bus.flush_flag)  bus.pc = fq[FLUSH_LAT-1];
        else if (stall)           bus.pc = bus.pc_now;
        else if (ras_ok)          bus.pc = ras_top;
        else if (bus.jmp_pred)    bus.pc = bus.pc_jmp;
    end

    // Alternate path: fall-through when redirecting, target otherwise.
    always_comb begin
        alt = bus.pc_jmp;
        if (!bus.flush_flag && !stall && (ras_ok || bus.jmp_pred)) alt = seq;
    end

    // Recovery queue next value: alt enters at the head, others shift up.
    for (genvar i = 0; i < FLUSH_LAT; i++) begin : g_fq
        if (i == 0) begin : g_head
            assign fq_d[i] = alt;
        end else begin : g_tail
            assign fq_d[i] = fq[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fq <= '0;
        else if (bus.flush_flag) fq <= '0;
        else if (!stall)         fq <= fq_d;
    end

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (adv & bus.is_call & (bus.jmp_pred | ras_hit_c)),
        .pop   (ras_hit_c),
        .clr   (bus.flush_flag),
        .din   (seq),
        .top   (ras_top),
        .cnt   (bus.ras_cnt)
    );

endmodule

// File: tb/tb_pc_gen_ras.sv
// Self-checking bench for pc_gen_ras (PC_W=16, RESET_PC=0x0100,
// FLUSH_LAT=2, RAS_DEPTH=4). Inputs change on the falling edge; pc and
// ras_hit are sampled 1 ns later; ras_cnt is the value before the next edge.
module tb_pc_gen_ras;

    localparam logic [7:0] MV = 8'h80, FL = 8'h40, WE = 8'h20, WJ = 8'h10,
                           DC = 8'h08, JP = 8'h04, CA = 8'h02, RE = 8'h01;

    typedef struct {
        logic [7:0]  ctl;
        logic [15:0] now;
        logic [15:0] jmp;
        logic [15:0] e_pc;
        logic        e_hit;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic        hit;
        logic [2:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    pc_gen_ras_if #(.PC_W(16), .RAS_DEPTH(4)) bus ();

    pc_gen_ras #(
        .PC_W      (16),
        .RESET_PC  (32'h0100),
        .FLUSH_LAT (2),
        .RAS_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] c, input logic [15:0] now, input logic [15:0] jmp,
                                input logic [15:0] ep, input logic eh, input logic [2:0] ec);
        vec_t v;
        v.ctl = c; v.now = now; v.jmp = jmp; v.e_pc = ep; v.e_hit = eh; v.e_cnt = ec;
        return v;
    endfunction

    // Apply one cycle of stimulus and queue its expected outputs.
    task automatic drive(input vec_t v);
        bus.pc_move    = v.ctl[7];
        bus.flush_flag = v.ctl[6];
        bus.wait_exe   = v.ctl[5];
        bus.wait_jmp   = v.ctl[4];
        bus.decompr_en = v.ctl[3];
        bus.jmp_pred   = v.ctl[2];
        bus.is_call    = v.ctl[1];
        bus.is_ret     = v.ctl[0];
        bus.pc_now     = v.now;
        bus.pc_jmp     = v.jmp;
        sb.push_back('{pc: v.e_pc, hit: v.e_hit, cnt: v.e_cnt});
    endtask

    task automatic test_reset();
        vec_t q[$];
        exp_t e;
        rst_n = 1'b0;
        drive(mk(8'h00, 16'h0000, 16'h0000, 16'h0100, 1'b0, 3'd0));
        #1;
        e = sb.pop_front();
        n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL reset_pc got %h exp %h", bus.pc, e.pc); end
        n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL reset_hit got %b exp %b", bus.ras_hit, e.hit); end
        n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL reset_cnt got %0d exp %0d", bus.ras_cnt, e.cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(mk(8'h00,   16'h0100, 16'h0000, 16'h0100, 1'b0, 3'd0));
        q.push_back(mk(MV | DC, 16'h0100, 16'h0000, 16'h0102, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL reset[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL reset[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL reset[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_jump_flush();
        vec_t q[$];
        exp_t e;
        q.push_back(mk(MV | JP, 16'h0200, 16'h0400, 16'h0400, 1'b0, 3'd0));
        q.push_back(mk(MV,      16'h0400, 16'h0000, 16'h0404, 1'b0, 3'd0));
        q.push_back(mk(MV | FL, 16'h0404, 16'h0000, 16'h0204, 1'b0, 3'd0));
        q.push_back(mk(MV | FL, 16'h0204, 16'h0000, 16'h0000, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL flush[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL flush[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL flush[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_call_ret();
        vec_t q[$];
        exp_t e;
        q.push_back(mk(MV | JP | CA, 16'h0300, 16'h0800, 16'h0800, 1'b0, 3'd0));
        q.push_back(mk(MV,           16'h0800, 16'h0000, 16'h0804, 1'b0, 3'd1));
        q.push_back(mk(MV | RE,      16'h0810, 16'h0000, 16'h0304, 1'b1, 3'd1));
        q.push_back(mk(MV,           16'h0304, 16'h0000, 16'h0308, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL call_ret[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL call_ret[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL call_ret[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    // Call and return in the same instruction: top replaced, count held.
    task automatic test_back_to_back();
        vec_t q[$];
        exp_t e;
        q.push_back(mk(MV | JP | CA, 16'h0500, 16'h0600, 16'h0600, 1'b0, 3'd0));
        q.push_back(mk(MV | CA | RE, 16'h0600, 16'h0000, 16'h0504, 1'b1, 3'd1));
        q.push_back(mk(MV | RE,      16'h0700, 16'h0000, 16'h0604, 1'b1, 3'd1));
        q.push_back(mk(MV,           16'h0604, 16'h0000, 16'h0608, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL b2b[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL b2b[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL b2b[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    // Five calls into a four-deep stack, then five returns.
    task automatic test_ras_overflow();
        vec_t q[$];
        exp_t e;
        for (int k = 0; k < 5; k++)
            q.push_back(mk(MV | JP | CA, 16'h1000 + 16'(k * 'h100), 16'h2000, 16'h2000, 1'b0,
                           3'(k > 4 ? 4 : k)));
        for (int j = 0; j < 4; j++)
            q.push_back(mk(MV | JP | RE, 16'h2000, 16'h3000, 16'h1404 - 16'(j * 'h100), 1'b1, 3'(4 - j)));
        q.push_back(mk(MV | JP | RE, 16'h2000, 16'h3000, 16'h3000, 1'b0, 3'd0));
        q.push_back(mk(MV,           16'h3000, 16'h0000, 16'h3004, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL ras_ovf[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL ras_ovf[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL ras_ovf[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    // Stalls hold queue and stack; flush beats a same-cycle stall.
    task automatic test_stall();
        vec_t q[$];
        exp_t e;
        q.push_back(mk(MV | JP | CA, 16'h0900, 16'h0A00, 16'h0A00, 1'b0, 3'd0));
        for (int k = 0; k < 3; k++)
            q.push_back(mk(MV | WE | JP | RE, 16'h0A00, 16'h0B00, 16'h0A00, 1'b0, 3'd1));
        q.push_back(mk(MV | WJ,      16'h0A00, 16'h0B00, 16'h0A00, 1'b0, 3'd1));
        q.push_back(mk(MV | RE,      16'h0A00, 16'h0000, 16'h0904, 1'b1, 3'd1));
        q.push_back(mk(MV | WE | FL, 16'h0C00, 16'h0000, 16'h0904, 1'b0, 3'd0));
        q.push_back(mk(MV,           16'h0904, 16'h0000, 16'h0908, 1'b0, 3'd0));
        q.push_back(mk(MV | FL,      16'h0908, 16'h0000, 16'h0000, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL stall[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL stall[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL stall[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        vec_t q[$];
        exp_t e;
        q.push_back(mk(MV,      16'hFFFE, 16'h0000, 16'h0002, 1'b0, 3'd0));
        q.push_back(mk(MV | DC, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 3'd0));
        q.push_back(mk(MV,      16'hFFFC, 16'h0000, 16'h0000, 1'b0, 3'd0));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL wrap[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_hit !== e.hit) begin n_fail++; $display("FAIL wrap[%0d] hit got %b exp %b", i, bus.ras_hit, e.hit); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL wrap[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
    endtask

    // Reset in the middle of a run clears stack count and queue at once.
    task automatic test_reset_mid();
        vec_t q[$];
        exp_t e;
        q.push_back(mk(MV | JP | CA, 16'h1234, 16'h2000, 16'h2000, 1'b0, 3'd0));
        q.push_back(mk(MV,           16'h2000, 16'h5555, 16'h2004, 1'b0, 3'd1));
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]); #1; e = sb.pop_front();
            n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL rst_mid[%0d] pc got %h exp %h", i, bus.pc, e.pc); end
            n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL rst_mid[%0d] cnt got %0d exp %0d", i, bus.ras_cnt, e.cnt); end
            @(negedge clk);
        end
        drive(mk(8'h00, 16'h2004, 16'h0000, 16'h0100, 1'b0, 3'd0));
        #2;
        rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL rst_mid_async cnt got %0d exp %0d", bus.ras_cnt, e.cnt); end
        n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL rst_mid_async pc got %h exp %h", bus.pc, e.pc); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(MV | FL, 16'h2004, 16'h0000, 16'h0000, 1'b0, 3'd0));
        #1;
        e = sb.pop_front();
        n_chk++; if (bus.pc !== e.pc) begin n_fail++; $display("FAIL rst_mid_fq pc got %h exp %h", bus.pc, e.pc); end
        n_chk++; if (bus.ras_cnt !== e.cnt) begin n_fail++; $display("FAIL rst_mid_fq cnt got %0d exp %0d", bus.ras_cnt, e.cnt); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_jump_flush();
        test_call_ret();
        test_back_to_back();
        test_ras_overflow();
        test_stall();
        test_wrap();
        test_reset_mid();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
